// File: rtl/ras_if.sv
// ras_if: predictor-to-RAS event bus and the RAS state exposed back for BCB checkpointing.
interface ras_if #(
    parameter int RAS_ENTRIES     = 16,
    parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
);
    logic                     link_valid;
    logic [37:0]              link_pc38;
    logic                     ret_valid;
    logic [37:0]              ret_pc38;
    logic                     ret_empty;
    logic [LOG_RAS_ENTRIES-1:0] ras_index;
    logic [LOG_RAS_ENTRIES:0]   ras_count;
    logic                     update_valid;
    logic [LOG_RAS_ENTRIES-1:0] update_ras_index;
    logic [LOG_RAS_ENTRIES:0]   update_ras_count;

    modport master (
        output link_valid, link_pc38, ret_valid, update_valid, update_ras_index, update_ras_count,
        input  ret_pc38, ret_empty, ras_index, ras_count
    );
    modport slave (
        input  link_valid, link_pc38, ret_valid, update_valid, update_ras_index, update_ras_count,
        output ret_pc38, ret_empty, ras_index, ras_count
    );
endinterface

// File: rtl/ras.sv
// ras: return address stack with BCB checkpoint restore.
// RAS_EMPTY_POP_HOLD_EN freezes the pointer on a pop while empty.
module ras #(
    parameter int RAS_ENTRIES     = 16,
    parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
) (
    input logic CLK,
    input logic nRST,
    ras_if.slave bus
);
    typedef logic [37:0]                pc38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] ras_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   ras_cnt_t;

    localparam ras_cnt_t FULL = ras_cnt_t'(RAS_ENTRIES);

    pc38_t    stack_q [RAS_ENTRIES];
    ras_idx_t sp_q, sp_d, top, wr_idx;
    ras_cnt_t cnt_q, cnt_d;
    logic     wr_en;

    assign top = sp_q - ras_idx_t'(1);

    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        if (bus.update_valid) begin
            sp_d  = bus.update_ras_index;
            cnt_d = (bus.update_ras_count > FULL) ? FULL : bus.update_ras_count;
        end else if (bus.ret_valid && bus.link_valid) begin
            // RET_L replaces the top in place, even when empty
            wr_en  = 1'b1;
            wr_idx = top;
        end else if (bus.ret_valid) begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - ras_cnt_t'(1);
`ifdef RAS_EMPTY_POP_HOLD_EN
            sp_d  = (cnt_q == '0) ? sp_q : top;
`else
            sp_d  = top;
`endif
        end else if (bus.link_valid) begin
            wr_en = 1'b1;
            sp_d  = sp_q + ras_idx_t'(1);
            cnt_d = (cnt_q == FULL) ? FULL : cnt_q + ras_cnt_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) stack_q[i] <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) stack_q[wr_idx] <= bus.link_pc38;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ret_pc38  = stack_q[top];
    assign bus.ret_empty = (cnt_q == '0);
    assign bus.ras_index = sp_q;
    assign bus.ras_count = cnt_q;
endmodule

// File: tb/tb_ras.sv
// tb_ras: directed and randomized checks of ras against a modular-arithmetic stack model.
module tb_ras;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int total = 0;
    int bad = 0;

`ifdef RAS_EMPTY_POP_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    ras_if bus ();
    ras dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    logic [37:0] m [16];
    int msp, mcnt;

    function automatic logic [37:0] mtop();
        return m[(msp + 15) % 16];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = '0;
        msp = 0;
        mcnt = 0;
    endtask

    task automatic idle_inputs();
        bus.link_valid = 0; bus.link_pc38 = '0; bus.ret_valid = 0;
        bus.update_valid = 0; bus.update_ras_index = '0; bus.update_ras_count = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 0;
        model_reset();
        #12;
        @(negedge CLK) nRST = 1;
    endtask

    task automatic do_op(input bit lv, input logic [37:0] lpc, input bit rv,
                         input bit uv, input int ui, input int uc);
        bus.link_valid = lv; bus.link_pc38 = lpc; bus.ret_valid = rv;
        bus.update_valid = uv; bus.update_ras_index = 4'(ui); bus.update_ras_count = 5'(uc);
        @(posedge CLK);
        if (uv) begin
            msp = ui;
            mcnt = (uc > 16) ? 16 : uc;
        end else if (rv && lv) begin
            m[(msp + 15) % 16] = lpc;
        end else if (rv) begin
            if (!(HOLD && mcnt == 0)) msp = (msp + 15) % 16;
            if (mcnt > 0) mcnt--;
        end else if (lv) begin
            m[msp] = lpc;
            msp = (msp + 1) % 16;
            if (mcnt < 16) mcnt++;
        end
        #1 idle_inputs();
    endtask

    task automatic push(input logic [37:0] pc); do_op(1, pc, 0, 0, 0, 0); endtask
    task automatic pop(); do_op(0, '0, 1, 0, 0, 0); endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (bus.ret_pc38 !== 38'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", bus.ret_pc38); end
        total++; if (bus.ret_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", bus.ret_empty); end
        total++; if (bus.ras_index !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.ras_index); end
        total++; if (bus.ras_count !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.ras_count); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push(38'h100); push(38'h200); push(38'h300);
        total++; if (bus.ras_index !== 4'd3) begin bad++; $display("FAIL push3_idx got=%0d exp=3", bus.ras_index); end
        total++; if (bus.ras_count !== 5'd3) begin bad++; $display("FAIL push3_cnt got=%0d exp=3", bus.ras_count); end
        total++; if (bus.ret_pc38 !== 38'h300) begin bad++; $display("FAIL push3_pc got=%0h exp=300", bus.ret_pc38); end
        total++; if (bus.ret_empty !== 1'b0) begin bad++; $display("FAIL push3_empty got=%0b exp=0", bus.ret_empty); end
        pop();
        total++; if (bus.ret_pc38 !== 38'h200) begin bad++; $display("FAIL pop1_pc got=%0h exp=200", bus.ret_pc38); end
        pop();
        total++; if (bus.ret_pc38 !== 38'h100) begin bad++; $display("FAIL pop2_pc got=%0h exp=100", bus.ret_pc38); end
        total++; if (bus.ras_index !== 4'd1) begin bad++; $display("FAIL pop2_idx got=%0d exp=1", bus.ras_index); end
        total++; if (bus.ras_count !== 5'd1) begin bad++; $display("FAIL pop2_cnt got=%0d exp=1", bus.ras_count); end
        pop();
        total++; if (bus.ret_empty !== 1'b1) begin bad++; $display("FAIL pop3_empty got=%0b exp=1", bus.ret_empty); end
        total++; if (bus.ras_index !== 4'd0) begin bad++; $display("FAIL pop3_idx got=%0d exp=0", bus.ras_index); end
    endtask

    task automatic test_saturate();
        logic [37:0] a [17];
        do_reset();
        for (int i = 0; i < 17; i++) begin
            a[i] = 38'h1000 + 38'(i * 38'h111);
            push(a[i]);
        end
        total++; if (bus.ras_count !== 5'd16) begin bad++; $display("FAIL sat_cnt got=%0d exp=16", bus.ras_count); end
        total++; if (bus.ras_index !== 4'd1) begin bad++; $display("FAIL sat_idx got=%0d exp=1", bus.ras_index); end
        for (int k = 0; k < 16; k++) begin
            total++; if (bus.ret_pc38 !== a[16 - k]) begin bad++; $display("FAIL sat_pop%0d_pc got=%0h exp=%0h", k, bus.ret_pc38, a[16 - k]); end
            pop();
        end
        total++; if (bus.ras_count !== 5'd0) begin bad++; $display("FAIL sat_drain_cnt got=%0d exp=0", bus.ras_count); end
    endtask

    task automatic test_ret_link();
        do_reset();
        push(38'hAAA);
        do_op(1, 38'hBBB, 1, 0, 0, 0);
        total++; if (bus.ret_pc38 !== 38'hBBB) begin bad++; $display("FAIL retl_pc got=%0h exp=bbb", bus.ret_pc38); end
        total++; if (bus.ras_index !== 4'd1) begin bad++; $display("FAIL retl_idx got=%0d exp=1", bus.ras_index); end
        total++; if (bus.ras_count !== 5'd1) begin bad++; $display("FAIL retl_cnt got=%0d exp=1", bus.ras_count); end
    endtask

    task automatic test_update();
        do_reset();
        for (int i = 1; i <= 7; i++) push(38'h5000 + 38'(i));
        do_op(1, 38'h3FFFFFFFFF, 0, 1, 5, 5);
        total++; if (bus.ras_index !== 4'd5) begin bad++; $display("FAIL upd_idx got=%0d exp=5", bus.ras_index); end
        total++; if (bus.ras_count !== 5'd5) begin bad++; $display("FAIL upd_cnt got=%0d exp=5", bus.ras_count); end
        total++; if (bus.ret_pc38 !== 38'h5005) begin bad++; $display("FAIL upd_pc got=%0h exp=5005", bus.ret_pc38); end
        do_op(0, '0, 1, 1, 3, 31);
        total++; if (bus.ras_count !== 5'd16) begin bad++; $display("FAIL upd_clamp_cnt got=%0d exp=16", bus.ras_count); end
        total++; if (bus.ras_index !== 4'd3) begin bad++; $display("FAIL upd_clamp_idx got=%0d exp=3", bus.ras_index); end
    endtask

    task automatic test_empty_pop();
        do_reset();
        pop();
        total++; if (bus.ras_index !== (HOLD ? 4'd0 : 4'd15)) begin bad++; $display("FAIL epop_idx got=%0d exp=%0d", bus.ras_index, HOLD ? 0 : 15); end
        total++; if (bus.ras_count !== 5'd0) begin bad++; $display("FAIL epop_cnt got=%0d exp=0", bus.ras_count); end
        total++; if (bus.ret_empty !== 1'b1) begin bad++; $display("FAIL epop_empty got=%0b exp=1", bus.ret_empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(38'h77); push(38'h88);
        #2 nRST = 0;
        #1;
        total++; if (bus.ras_index !== 4'd0 || bus.ras_count !== 5'd0) begin bad++; $display("FAIL areset_state got=%0d/%0d exp=0/0", bus.ras_index, bus.ras_count); end
        total++; if (bus.ret_pc38 !== 38'h0 || bus.ret_empty !== 1'b1) begin bad++; $display("FAIL areset_out got=%0h/%0b exp=0/1", bus.ret_pc38, bus.ret_empty); end
        model_reset();
        @(negedge CLK) nRST = 1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) push({$urandom, 6'($urandom)});
            else if (r < 75) pop();
            else if (r < 87) do_op(1, {$urandom, 6'($urandom)}, 1, 0, 0, 0);
            else if (r < 95) do_op($urandom_range(0, 1), 38'h1, $urandom_range(0, 1), 1, $urandom_range(0, 15), $urandom_range(0, 31));
            else do_op(0, '0, 0, 0, 0, 0);
            total++;
            if (bus.ret_pc38 !== mtop() || bus.ret_empty !== (mcnt == 0) ||
                bus.ras_index !== 4'(msp) || bus.ras_count !== 5'(mcnt)) begin
                bad++;
                $display("FAIL rand%0d got pc=%0h e=%0b i=%0d c=%0d exp pc=%0h e=%0b i=%0d c=%0d", n,
                         bus.ret_pc38, bus.ret_empty, bus.ras_index, bus.ras_count, mtop(), mcnt == 0, msp, mcnt);
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_push_pop();
        test_saturate();
        test_ret_link();
        test_update();
        test_empty_pop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
